// File: rtl/ascon_round_sequencer_if.sv
// Request/result handshake bundle between the Ascon mode layer (master) and the
// round sequencer (slave).
interface ascon_round_sequencer_if;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [4:0]   num_rounds_i;
  logic [319:0] state_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [319:0] state_o;

  modport master (
    output in_valid_i, num_rounds_i, state_i, out_ready_i,
    input  in_ready_o, out_valid_o, state_o
  );

  modport slave (
    input  in_valid_i, num_rounds_i, state_i, out_ready_i,
    output in_ready_o, out_valid_o, state_o
  );
endinterface

// File: rtl/ascon_round_sequencer.sv
// Iterative Ascon-p[rnd] controller: one round per clock through an external datapath.
// Optional macro ASCON_SEQ_ABORT_EN adds an abort_i input that drops RUN/DONE back to IDLE.
module ascon_round_sequencer #(
  parameter int DEFAULT_ROUNDS = 12
) (
  input  logic         clk_i,
  input  logic         rst_i,
`ifdef ASCON_SEQ_ABORT_EN
  input  logic         abort_i,
`endif
  ascon_round_sequencer_if.slave bus,
  output logic [3:0]   rnd_o,
  output logic [319:0] round_state_o,
  input  logic [319:0] round_state_i,
  output logic         busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_e;

  localparam logic [3:0] LAST_RND    = 4'hF;
  localparam logic [4:0] DEF_ROUNDS5 = 5'(DEFAULT_ROUNDS);

  fsm_e         fsm_q, fsm_d;
  logic [319:0] st_q, st_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;

  logic [4:0]   n_eff;
  logic [4:0]   rnd_start;
  logic         abort_w;

`ifdef ASCON_SEQ_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  // Zero picks the default count; anything above 16 clamps to the full schedule.
  always_comb begin
    if (bus.num_rounds_i == 5'd0)
      n_eff = DEF_ROUNDS5;
    else if (bus.num_rounds_i > 5'd16)
      n_eff = 5'd16;
    else
      n_eff = bus.num_rounds_i;
    rnd_start = 5'd16 - n_eff;
  end

  always_comb begin
    fsm_d       = fsm_q;
    st_d        = st_q;
    rnd_d       = rnd_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (fsm_q)
      S_IDLE: begin
        if (bus.in_valid_i && in_ready_q) begin
          st_d       = bus.state_i;
          rnd_d      = rnd_start[3:0];
          fsm_d      = S_RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_RUN: begin
        st_d = round_state_i;
        if (rnd_q == LAST_RND) begin
          fsm_d       = S_DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_DONE: begin
        if (bus.out_ready_i) begin
          fsm_d       = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        fsm_d       = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase

    // Abort discards any in-flight or pending result.
    if (abort_w && fsm_q != S_IDLE) begin
      fsm_d       = S_IDLE;
      st_d        = '0;
      rnd_d       = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q       <= S_IDLE;
      st_q        <= '0;
      rnd_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      st_q        <= st_d;
      rnd_q       <= rnd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.state_o     = st_q;
  assign round_state_o   = st_q;
  assign rnd_o           = rnd_q;
  assign busy_o          = busy_q;

endmodule
